serial_adder_controller: RTL and testbench
==========================================

Name: serial_adder_controller

Overview:
- Bit-serial adder sequencer around exactly one `full_adder` instance, LSB first, one bit per clock.
- Captures two WIDTH-bit operands and a carry-in through a valid/ready input handshake.
- Drives the adder from operand shift registers and holds the running carry in a flip-flop.
- Presents the WIDTH-bit sum and final carry on a valid/ready output handshake.
- Area-cheap alternative to the parallel adders for low-throughput paths.

Parameters:
- WIDTH, 8: operand/sum width in bits; legal range 1..64; elaboration error outside it.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept; high only in IDLE.
- operand_1  input  WIDTH  first addend.
- operand_2  input  WIDTH  second addend.
- carry_in  input  1  initial carry.
- out_valid  output  1  result present; high only in DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result word.
- carry_out  output  1  final carry.
- busy  output  1  high in RUN.

Behaviour:
- Clock and reset: one clock (clock). Reset (reset) is asynchronous and active-high.
- While reset is high:
  - state=IDLE; operand shift regs, sum reg, carry flop, bit counter all 0.
  - out_valid=0, sum=0, carry_out=0, busy=0; in_ready=1.
  - in_valid is ignored.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture operand_1, operand_2 into shift regs, carry_in into the carry flop, clear counter, go to RUN.
  - Input changes after capture have no effect.
- RUN:
  - busy=1, in_ready=0.
  - `full_adder` inputs are operand_1 shift reg bit 0, operand_2 shift reg bit 0, and the carry flop.
  - Each edge:
    - both operand regs shift right by 1;
    - sum reg shifts right with the adder sum entering the MSB;
    - carry flop takes the adder carry_out;
    - counter increments.
  - When the counter reaches WIDTH-1 on an edge (i.e. the WIDTH-th RUN edge), go to DONE.
- DONE:
  - out_valid=1; sum=sum reg; carry_out=carry flop.
  - Both outputs stay stable until out_ready=1 at an edge, then go to IDLE.
  - out_ready while not DONE is ignored.
- Timing:
  - Accept edge = edge 0; out_valid is high after edge WIDTH.
  - With out_ready held high, result transfers at edge WIDTH+1.
  - Back-to-back throughput is one operation per WIDTH+2 cycles; no overlap of input and output phases.
- sum and carry_out are registered; in DONE they equal the full-width sum of operand_1 + operand_2 + carry_in, split into {carry_out, sum}. Outside DONE they hold the last result (0 after reset) and are only meaningful with out_valid.
- WIDTH=1: RUN lasts exactly one edge.
- Reset asserted mid-RUN or in DONE: immediate return to the reset state; partial result discarded; no out_valid pulse.
- Counter width is clog2(WIDTH+1); it never wraps within one operation.

Optional Feature:
- Macro: SERIAL_ADDER_SUBTRACT_EN.
- When defined:
  - Extra input port subtract (1 bit), sampled at the accept edge.
  - If subtract=1: operand_2 is captured bitwise inverted and the carry flop is loaded with 1, ignoring carry_in. Result is operand_1 - operand_2 modulo 2^WIDTH, with carry_out=1 meaning no borrow.
  - If subtract=0: identical to the base behaviour.
- When undefined: no subtract port, and the logic is exactly the base block.

Test Plan:
- WIDTH=8; 0x5A + 0x3C, carry_in=0, out_ready=1 -> sum=0x96, carry_out=0; out_valid rises 8 edges after accept and lasts 1 cycle; busy high for exactly 8 cycles.
- 0xFF + 0x01, carry_in=0 -> sum=0x00, carry_out=1. Then 0xFF + 0xFF, carry_in=1 -> sum=0xFF, carry_out=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/carry_out stable, in_ready=0. A new in_valid applied during this window is not accepted. Raising out_ready -> IDLE next edge, in_ready=1.
- Input stability: change operand_1/operand_2 every cycle during RUN after accepting 0x12 + 0x34 -> sum=0x46.
- Reset: assert reset at RUN cycle 3 of 0xAA + 0x55 -> out_valid, sum, carry_out, busy all 0 immediately. The next accepted 0x01 + 0x01 gives 0x02, with carry_out=0.
- With SERIAL_ADDER_SUBTRACT_EN: 0x10 - 0x01 -> sum=0x0F, carry_out=1. Then 0x01 - 0x02 -> sum=0xFF, carry_out=0.

Source files
------------

// File: rtl/serial_adder_controller.sv
// Bit-serial adder sequencer: one full_adder, LSB first, one bit per clock, valid/ready in and out.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUBTRACT_EN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_controller #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
`ifdef SERIAL_ADDER_SUBTRACT_EN
    ,
    input  logic             subtract
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
            $error("serial_adder_controller: WIDTH must be in 1..64");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   op1_r;
    logic [WIDTH-1:0]   op2_r;
    logic [WIDTH-1:0]   acc_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_out_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    logic               fa_sum_s;
    logic               fa_cout_s;
    logic [WIDTH:0]     shift_s;
    logic [WIDTH-1:0]   cap_op2_s;
    logic               cap_carry_s;

    full_adder u_full_adder (
        .a    (op1_r[0]),
        .b    (op2_r[0]),
        .cin  (carry_r),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // New adder sum bit enters at the MSB; the wide concat keeps WIDTH=1 legal.
    assign shift_s = {fa_sum_s, acc_r};

    // Operand-2 and initial carry selection at the accept edge.
    always_comb begin
        cap_op2_s   = operand_2;
        cap_carry_s = carry_in;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        if (subtract) begin
            cap_op2_s   = ~operand_2;
            cap_carry_s = 1'b1;
        end else begin
            cap_op2_s   = operand_2;
            cap_carry_s = carry_in;
        end
`endif
    end

    // Sequencer FSM with datapath and registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op1_r       <= '0;
            op2_r       <= '0;
            acc_r       <= '0;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op1_r      <= operand_1;
                        op2_r      <= cap_op2_s;
                        carry_r    <= cap_carry_s;
                        cnt_r      <= '0;
                        state_r    <= ST_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    op1_r   <= op1_r >> 1;
                    op2_r   <= op2_r >> 1;
                    acc_r   <= shift_s[WIDTH:1];
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    // Result is published only once, so sum/carry_out hold steady outside DONE.
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        sum_r       <= shift_s[WIDTH:1];
                        carry_out_r <= fa_cout_s;
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign carry_out = carry_out_r;

endmodule

// File: tb/tb_serial_adder_controller.sv
// Self-checking bench for serial_adder_controller (WIDTH=8): vector table plus handshake/reset sequences.

module tb_serial_adder_controller;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] operand_1;
    logic [7:0] operand_2;
    logic       carry_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       carry_out;
    logic       busy;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    logic       subtract;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    typedef struct {
        logic [7:0] s;
        logic       co;
    } res_t;

    vec_t vecs [6];
    res_t sb_q [$];

    serial_adder_controller #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
`ifdef SERIAL_ADDER_SUBTRACT_EN
        ,
        .subtract  (subtract)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one operand set from IDLE; returns at #1 after the accept edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input bit push);
        logic [8:0] r;
        check("in_ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        operand_1 = a;
        operand_2 = b;
        carry_in  = cin;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        subtract  = sub;
`endif
        tick();
        in_valid = 1'b0;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + 9'd1;
        else     r = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        if (push) sb_q.push_back('{s: r[7:0], co: r[8]});
    endtask

    // Wait (bounded) for out_valid, counting busy cycles, then compare against the scoreboard.
    task automatic receive(input string tag, output int lat, output int bc);
        res_t e;
        lat = 0;
        bc  = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bc++;
            tick();
            lat++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 0, 1);
        end else if (sb_q.size() == 0) begin
            check({tag, "_unexpected_result"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_sum"}, sum, e.s);
            check({tag, "_carry_out"}, carry_out, e.co);
        end
    endtask

    initial begin
        int lat;
        int bc;
        logic [7:0] held_s;
        logic       held_c;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, s: 8'h96, co: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, co: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, co: 1'b1};
        vecs[5] = '{a: 8'hA5, b: 8'h0F, cin: 1'b1, s: 8'hB5, co: 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b1;
        operand_1 = 8'h11;
        operand_2 = 8'h22;
        carry_in  = 1'b1;
        out_ready = 1'b1;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        subtract  = 1'b0;
`endif
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry_out", carry_out, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        tick();
        check("rst_ignores_in_valid", busy, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Table-driven operations with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 1'b0);
            sb_q.push_back('{s: vecs[i].s, co: vecs[i].co});
            receive($sformatf("vec%0d", i), lat, bc);
            check($sformatf("vec%0d_latency", i), lat, 8);
            check($sformatf("vec%0d_busy_cycles", i), bc, 8);
            tick();
            check($sformatf("vec%0d_valid_one_cycle", i), out_valid, 0);
            check($sformatf("vec%0d_back_to_idle", i), in_ready, 1);
        end

        // Backpressure: result held, in_valid ignored while DONE.
        out_ready = 1'b0;
        send(8'h77, 8'h11, 1'b0, 1'b0, 1'b1);
        receive("bp", lat, bc);
        held_s = sum;
        held_c = carry_out;
        in_valid  = 1'b1;
        operand_1 = 8'h01;
        operand_2 = 8'h01;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid_held", out_valid, 1);
            check("bp_sum_stable", sum, held_s);
            check("bp_carry_stable", carry_out, held_c);
            check("bp_in_ready_low", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        tick();
        check("bp_no_stray_accept", busy, 0);

        // Operands wiggle during RUN; result must use captured values.
        send(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            operand_1 = 8'($urandom_range(255));
            operand_2 = 8'($urandom_range(255));
            carry_in  = ~carry_in;
            tick();
        end
        carry_in = 1'b0;
        receive("stable", lat, bc);
        tick();

        // Reset in the middle of RUN discards the operation.
        send(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("midrun_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_sum", sum, 0);
        check("midrun_rst_carry_out", carry_out, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_in_ready", in_ready, 1);
        tick();
        reset = 1'b0;
        bc = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) bc++;
        end
        check("midrun_no_valid_pulse", bc, 0);
        send(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        receive("after_rst", lat, bc);
        tick();

`ifdef SERIAL_ADDER_SUBTRACT_EN
        send(8'h10, 8'h01, 1'b1, 1'b1, 1'b1);
        receive("sub0", lat, bc);
        check("sub0_sum_const", sum, 8'h0F);
        check("sub0_carry_const", carry_out, 1);
        tick();
        send(8'h01, 8'h02, 1'b0, 1'b1, 1'b1);
        receive("sub1", lat, bc);
        check("sub1_sum_const", sum, 8'hFF);
        check("sub1_carry_const", carry_out, 0);
        tick();
        subtract = 1'b0;
`endif

        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
